// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader
//  Purpose  : Receives a program image as a byte stream (16-bit word count,
//             little-endian data words, XOR checksum), writes the words into
//             instruction memory and keeps the processor in reset until the
//             image has been loaded and its checksum matches.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              proc_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    ST_CNT_LO = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt_lo;
  logic [15:0] word_count;
  logic [31:0] word_sr;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;

  logic        accept;
  logic [16:0] cnt_full;
  logic [31:0] word_next;
  logic [16:0] words_after;
  logic        last_word;

  // Bytes are only taken while a load is in progress; there is no
  // backpressure inside a load.
  assign in_ready    = (state != ST_DONE) && (state != ST_ERROR);
  assign accept      = in_valid && in_ready;
  assign cnt_full    = {1'b0, in_data, cnt_lo};
  // Bytes enter at the top and move down, so the first byte ends in [7:0].
  assign word_next   = {in_data, word_sr[31:8]};
  assign words_after = 17'(words_loaded) + 17'd1;
  assign last_word   = (words_after == {1'b0, word_count});

  // State register.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) state <= ST_CNT_LO;
    else       state <= state_nxt;
  end

  // Next-state decode; every transition except the start restart needs an
  // accepted byte.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CNT_LO: if (accept) state_nxt = ST_CNT_HI;
      ST_CNT_HI: begin
        if (accept) begin
          if (cnt_full > CAPACITY)   state_nxt = ST_ERROR;
          else if (cnt_full == '0)   state_nxt = ST_CHECK;
          else                       state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (accept && (byte_idx == 2'd3) && last_word) state_nxt = ST_CHECK;
      ST_CHECK:  if (accept) state_nxt = (in_data == csum) ? ST_DONE : ST_ERROR;
      ST_DONE,
      ST_ERROR:  if (start) state_nxt = ST_CNT_LO;
      default:   state_nxt = ST_CNT_LO;
    endcase
  end

  // Datapath: count capture, word assembly, checksum, memory writes and the
  // registered status outputs.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      cnt_lo       <= '0;
      word_count   <= '0;
      word_sr      <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      proc_reset   <= 1'b1;
    end else begin
      imem_we    <= 1'b0;
      load_done  <= (state_nxt == ST_DONE);
      load_error <= (state_nxt == ST_ERROR);
      // Released one cycle after DONE is entered; re-held right after start.
      proc_reset <= !((state == ST_DONE) && !start);
      case (state)
        ST_CNT_LO: if (accept) cnt_lo <= in_data;
        ST_CNT_HI: if (accept) word_count <= {in_data, cnt_lo};
        ST_DATA: begin
          if (accept) begin
            word_sr  <= word_next;
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= word_next;
              words_loaded <= words_loaded + 1'b1;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (start) begin
            words_loaded <= '0;
            csum         <= '0;
            byte_idx     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_boot_loader
//  Purpose  : Self-checking bench for imem_boot_loader. Images are parsed by a
//             behavioural model that predicts the memory writes and the final
//             outcome; a monitor compares every imem_we against the prediction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;

  logic              clock = 1'b0;
  logic              Reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              proc_reset;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .Reset        (Reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .proc_reset   (proc_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  img[$];
  logic [31:0] words[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Every write strobe must match the next predicted write.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        check("spurious_we", 32'(imem_we), 32'd0);
      end else begin
        check("we_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
        check("we_data", imem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // Serialise a count plus the current word list into img; cs_flip corrupts
  // the checksum byte.
  task automatic make_image(input int n, input logic [7:0] cs_flip);
    logic [7:0]  cs;
    logic [31:0] w;
    img.delete();
    cs = 8'h00;
    img.push_back(n[7:0]);
    img.push_back(n[15:8]);
    foreach (words[i]) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        img.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    img.push_back(cs ^ cs_flip);
  endtask

  // Model the image, then stream it (up to limit bytes when limit >= 0) with
  // random idle gaps of 0..gap_max cycles. Called and returns at #1 after an edge.
  task automatic load(input int gap_max, input int limit);
    int         n;
    bit         too_big;
    bit         ok;
    int         full;
    int         nsend;
    logic [7:0] cs;
    n       = int'(img[0]) | (int'(img[1]) << 8);
    too_big = (n > (1 << ADDR_W));
    full    = too_big ? 2 : 2 + 4 * n + 1;
    nsend   = (limit >= 0 && limit < full) ? limit : full;
    cs      = 8'h00;
    ok      = 1'b0;
    if (!too_big) begin
      for (int i = 0; i < n; i++) begin
        if (2 + 4 * i + 3 < nsend) begin
          exp_addr.push_back(i);
          exp_data.push_back({img[5+4*i], img[4+4*i], img[3+4*i], img[2+4*i]});
        end
      end
      for (int i = 0; i < 4 * n; i++) cs = cs ^ img[2+i];
      ok = (img[2+4*n] == cs);
    end
    for (int k = 0; k < nsend; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
      check("in_ready_load", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = img[k];
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
    if (nsend == full) begin
      check("load_done", 32'(load_done), 32'(ok));
      check("load_error", 32'(load_error), 32'(!ok));
      check("words_loaded", 32'(words_loaded), too_big ? 32'd0 : 32'(n));
      check("proc_reset_entry", 32'(proc_reset), 32'd1);
      check("in_ready_end", 32'(in_ready), 32'd0);
      check("writes_pending", 32'(exp_addr.size()), 32'd0);
      @(posedge clock);
      #1;
      check("proc_reset_after", 32'(proc_reset), 32'(!ok));
      check("load_done_hold", 32'(load_done), 32'(ok));
    end
  endtask

  task automatic do_start();
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("start_proc_reset", 32'(proc_reset), 32'd1);
    check("start_done", 32'(load_done), 32'd0);
    check("start_error", 32'(load_error), 32'd0);
    check("start_words", 32'(words_loaded), 32'd0);
    check("start_ready", 32'(in_ready), 32'd1);
  endtask

  // Main sequence.
  initial begin
    Reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_proc_reset", 32'(proc_reset), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    Reset = 1'b0;
    @(posedge clock);
    #1;

    // Two known words, good checksum.
    words.delete();
    words.push_back(32'h20010005);
    words.push_back(32'h00000000);
    make_image(2, 8'h00);
    load(0, -1);

    // Corrupted checksum, then a good image after start.
    do_start();
    make_image(2, 8'h01);
    load(0, -1);
    do_start();
    make_image(2, 8'h00);
    load(1, -1);

    // Count one above capacity, then exactly capacity.
    do_start();
    words.delete();
    make_image(257, 8'h00);
    load(0, -1);
    do_start();
    rand_words(256);
    make_image(256, 8'h00);
    load(0, -1);

    // Empty image with good and bad checksum.
    do_start();
    words.delete();
    make_image(0, 8'h00);
    load(0, -1);
    do_start();
    make_image(0, 8'h5A);
    load(0, -1);

    // Same four-word image without and with idle gaps.
    do_start();
    rand_words(4);
    make_image(4, 8'h00);
    load(0, -1);
    do_start();
    load(7, -1);

    // Random images, some with a single corrupted checksum bit.
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 6);
      do_start();
      rand_words(n);
      make_image(n, ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      load(3, -1);
    end

    // Abort after six data bytes, then a one-word load from scratch.
    do_start();
    rand_words(2);
    make_image(2, 8'h00);
    load(2, 8);
    Reset = 1'b1;
    #2;
    check("abort_proc_reset", 32'(proc_reset), 32'd1);
    check("abort_words", 32'(words_loaded), 32'd0);
    check("abort_we", 32'(imem_we), 32'd0);
    @(posedge clock);
    #1;
    Reset = 1'b0;
    check("abort_pending", 32'(exp_addr.size()), 32'd0);
    rand_words(1);
    make_image(1, 8'h00);
    load(2, -1);

    repeat (3) @(posedge clock);
    #1;
    check("final_pending", 32'(exp_addr.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
